// File: rtl/rx_ber_prbs9_pkg.sv
// Shared types and constants for the PRBS9 BER checker: FSM states, generator taps
// and a ceil-log2 helper used to size the phase and window counters.
package rx_ber_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_e;

  // x^9 + x^5 + 1
  localparam int PRBS_TAP_HI = 9;
  localparam int PRBS_TAP_LO = 5;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >>> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rx_ber_prbs9_if.sv
// Oversampled symbol stream (one channel) feeding the BER checker.
interface rx_ber_prbs9_if #(
  parameter int NB_IN = 8
) ();
  logic signed [NB_IN-1:0] i_sample;
  logic                    i_valid;

  modport master (output i_sample, output i_valid);
  modport slave  (input  i_sample, input  i_valid);
endinterface

// File: rtl/rx_ber_prbs9_ref.sv
// Local PRBS9 reference: shift-loads sliced bits while searching, free-runs from
// its own prediction otherwise; also counts the 9 fill decisions of a search.
module rx_ber_prbs9_ref
  import rx_ber_pkg::*;
(
  input  logic clk,
  input  logic rst_ni,
  input  logic dec_valid_i,
  input  logic rx_bit_i,
  input  logic search_i,
  output logic pred_o,
  output logic fill_last_o,
  output logic ref_zero_o
);

  logic [8:0] ref_q, ref_d;
  logic [3:0] fill_q, fill_d;

  assign pred_o      = ref_q[PRBS_TAP_HI-1] ^ ref_q[PRBS_TAP_LO-1];
  assign fill_last_o = (fill_q == 4'd8);
  assign ref_zero_o  = (ref_q == 9'd0);

  always_comb begin
    ref_d  = ref_q;
    fill_d = fill_q;
    if (!search_i) fill_d = 4'd0;
    if (dec_valid_i) begin
      if (search_i) begin
        ref_d  = {ref_q[7:0], rx_bit_i};
        fill_d = fill_last_o ? 4'd0 : fill_q + 4'd1;
      end else begin
        ref_d  = {ref_q[7:0], pred_o};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ref_q  <= '0;
      fill_q <= '0;
    end else begin
      ref_q  <= ref_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/rx_ber_prbs9.sv
// PRBS9 BER checker for one I/Q channel: decimate, slice, self-sync, count bits/errors.
// Optional debug taps (decision bit/strobe, FSM state) when RX_BER_DEBUG_EN is defined.
module rx_ber_prbs9
  import rx_ber_pkg::*;
#(
  parameter int OVERSAMP = 4,
  parameter int NB_IN    = 8,
  parameter int NB_CNT   = 32,
  parameter int SYNC_WIN = 64,
  parameter int SYNC_THR = 4
) (
  input  logic                         clk,
  input  logic                         i_reset,
  rx_ber_prbs9_if.slave                s_if,
  input  logic [clog2(OVERSAMP)-1:0]   i_phase,
  input  logic                         i_clear,
  output logic                         o_lock,
  output logic [NB_CNT-1:0]            o_bit_cnt,
  output logic [NB_CNT-1:0]            o_err_cnt
`ifdef RX_BER_DEBUG_EN
  ,
  output logic                         o_dec_bit,
  output logic                         o_dec_valid,
  output logic [1:0]                   o_state
`endif
);

  localparam int PW  = clog2(OVERSAMP);
  localparam int WCW = clog2(SYNC_WIN);
  localparam int WEW = clog2(SYNC_WIN + 1);

  logic [PW-1:0]     phase_q;
  logic              dec_valid_q;
  logic              rx_bit_q;
  state_e            state_q;
  logic [WCW-1:0]    win_cnt_q;
  logic [WEW-1:0]    win_err_q;
  logic [WEW-1:0]    win_err_d;
  logic [NB_CNT-1:0] bit_cnt_q;
  logic [NB_CNT-1:0] err_cnt_q;
  logic              lock_q;
  logic              pred, fill_last, ref_zero, err, win_end, win_ok;

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      phase_q     <= '0;
      dec_valid_q <= 1'b0;
      rx_bit_q    <= 1'b0;
    end else begin
      if (s_if.i_valid) phase_q <= phase_q + 1'b1;
      dec_valid_q <= s_if.i_valid && (phase_q == i_phase);
      if (s_if.i_valid && (phase_q == i_phase)) rx_bit_q <= s_if.i_sample[NB_IN-1];
    end
  end

  rx_ber_prbs9_ref u_ref (
    .clk         (clk),
    .rst_ni      (i_reset),
    .dec_valid_i (dec_valid_q),
    .rx_bit_i    (rx_bit_q),
    .search_i    (state_q == ST_SEARCH),
    .pred_o      (pred),
    .fill_last_o (fill_last),
    .ref_zero_o  (ref_zero)
  );

  assign err       = rx_bit_q ^ pred;
  assign win_end   = (win_cnt_q == WCW'(SYNC_WIN - 1));
  assign win_err_d = win_err_q + WEW'(err);
  assign win_ok    = (win_err_d <= WEW'(SYNC_THR));

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= ST_SEARCH;
      win_cnt_q <= '0;
      win_err_q <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
      lock_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_SEARCH: begin
          if (dec_valid_q && fill_last) begin
            state_q   <= ST_VERIFY;
            win_cnt_q <= '0;
            win_err_q <= '0;
          end
        end
        ST_VERIFY: begin
          // a zero reference can never track a live PRBS, so resync at once
          if (ref_zero) begin
            state_q <= ST_SEARCH;
          end else if (dec_valid_q) begin
            if (win_end) begin
              state_q   <= win_ok ? ST_LOCK : ST_SEARCH;
              lock_q    <= win_ok;
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              win_err_q <= win_err_d;
            end
          end
        end
        ST_LOCK: begin
          if (dec_valid_q) begin
            if (!(&bit_cnt_q))        bit_cnt_q <= bit_cnt_q + 1'b1;
            if (err && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
            if (win_end) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
              if (!win_ok) begin
                state_q <= ST_SEARCH;
                lock_q  <= 1'b0;
              end
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              win_err_q <= win_err_d;
            end
          end
        end
        default: begin
          state_q <= ST_SEARCH;
          lock_q  <= 1'b0;
        end
      endcase
      if (i_clear) begin
        bit_cnt_q <= '0;
        err_cnt_q <= '0;
      end
    end
  end

  assign o_lock    = lock_q;
  assign o_bit_cnt = bit_cnt_q;
  assign o_err_cnt = err_cnt_q;

`ifdef RX_BER_DEBUG_EN
  assign o_dec_bit   = rx_bit_q;
  assign o_dec_valid = dec_valid_q;
  assign o_state     = 2'(state_q);
`endif

endmodule

// File: tb/tb_rx_ber_prbs9.sv
// Directed bench for rx_ber_prbs9: a default instance plus an NB_CNT=8 / SYNC_THR=64
// instance sharing the same stream, for saturation and the zero-reference rule.
module tb_rx_ber_prbs9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  i_phase;
  logic        i_clear;
  logic        lock0, lock1;
  logic [31:0] bit0, err0;
  logic [7:0]  bit1, err1;
  logic [8:0]  tx_q = 9'h1AA;
  int          n_vec = 0;
  int          n_err = 0;
  logic        seen0, seen1;

`ifdef RX_BER_DEBUG_EN
  logic       dbit0, dval0, dbit1, dval1;
  logic [1:0] dst0, dst1;
`endif

  rx_ber_prbs9_if #(.NB_IN(8)) s_if ();

  always #5 clk = ~clk;

  rx_ber_prbs9 #(.OVERSAMP(4), .NB_IN(8), .NB_CNT(32), .SYNC_WIN(64), .SYNC_THR(4)) dut0 (
    .clk(clk), .i_reset(rst_n), .s_if(s_if), .i_phase(i_phase), .i_clear(i_clear),
    .o_lock(lock0), .o_bit_cnt(bit0), .o_err_cnt(err0)
`ifdef RX_BER_DEBUG_EN
    , .o_dec_bit(dbit0), .o_dec_valid(dval0), .o_state(dst0)
`endif
  );

  rx_ber_prbs9 #(.OVERSAMP(4), .NB_IN(8), .NB_CNT(8), .SYNC_WIN(64), .SYNC_THR(64)) dut1 (
    .clk(clk), .i_reset(rst_n), .s_if(s_if), .i_phase(i_phase), .i_clear(i_clear),
    .o_lock(lock1), .o_bit_cnt(bit1), .o_err_cnt(err1)
`ifdef RX_BER_DEBUG_EN
    , .o_dec_bit(dbit1), .o_dec_valid(dval1), .o_state(dst1)
`endif
  );

  task automatic send_sym(input logic b);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      s_if.i_sample = b ? 8'hC0 : 8'h40;
      s_if.i_valid  = 1'b1;
    end
  endtask

  // n PRBS decisions; decision i is inverted when (i % imod) < icnt
  task automatic send_prbs(input int n, input int imod, input int icnt);
    logic b;
    for (int i = 0; i < n; i++) begin
      b    = tx_q[8] ^ tx_q[4];
      tx_q = {tx_q[7:0], b};
      send_sym(b ^ ((i % imod) < icnt));
    end
  endtask

  task automatic flush();
    @(posedge clk); #1;
    s_if.i_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (lock0 !== 1'b0) begin $display("FAIL rst_lock0: got %0d expected 0", lock0); n_err++; end
    n_vec++;
    if (bit0 !== 32'd0) begin $display("FAIL rst_bit0: got %0d expected 0", bit0); n_err++; end
    n_vec++;
    if (err0 !== 32'd0) begin $display("FAIL rst_err0: got %0d expected 0", err0); n_err++; end
    n_vec++;
    if (lock1 !== 1'b0) begin $display("FAIL rst_lock1: got %0d expected 0", lock1); n_err++; end
    n_vec++;
    if (bit1 !== 8'd0) begin $display("FAIL rst_bit1: got %0d expected 0", bit1); n_err++; end
    n_vec++;
    #3 rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    send_prbs(72, 1, 0); flush();
    if (lock0 !== 1'b0) begin $display("FAIL lock_at72: got %0d expected 0", lock0); n_err++; end
    n_vec++;
    send_prbs(1, 1, 0); flush();
    if (lock0 !== 1'b1) begin $display("FAIL lock_at73: got %0d expected 1", lock0); n_err++; end
    n_vec++;
    if (lock1 !== 1'b1) begin $display("FAIL lock1_at73: got %0d expected 1", lock1); n_err++; end
    n_vec++;
    if (bit0 !== 32'd0) begin $display("FAIL bit_at_lock: got %0d expected 0", bit0); n_err++; end
    n_vec++;
    send_prbs(1000, 1, 0); flush();
    if (bit0 !== 32'd1000) begin $display("FAIL clean_bit: got %0d expected 1000", bit0); n_err++; end
    n_vec++;
    if (err0 !== 32'd0) begin $display("FAIL clean_err: got %0d expected 0", err0); n_err++; end
    n_vec++;
    if (bit1 !== 8'd255) begin $display("FAIL bit_sat8: got %0d expected 255", bit1); n_err++; end
    n_vec++;
  endtask

  task automatic test_single_errors();
    send_prbs(1000, 100, 1); flush();
    if (err0 !== 32'd10) begin $display("FAIL single_err: got %0d expected 10", err0); n_err++; end
    n_vec++;
    if (bit0 !== 32'd2000) begin $display("FAIL single_bit: got %0d expected 2000", bit0); n_err++; end
    n_vec++;
    if (lock0 !== 1'b1) begin $display("FAIL single_lock: got %0d expected 1", lock0); n_err++; end
    n_vec++;
    if (err1 !== 8'd10) begin $display("FAIL single_err1: got %0d expected 10", err1); n_err++; end
    n_vec++;
  endtask

  // lock window sits at position 16 here: 48 decisions remain in it
  task automatic test_loss_of_lock();
    send_prbs(47, 1000, 8); flush();
    if (lock0 !== 1'b1) begin $display("FAIL loss_pre_end: got %0d expected 1", lock0); n_err++; end
    n_vec++;
    if (err0 !== 32'd18) begin $display("FAIL loss_err: got %0d expected 18", err0); n_err++; end
    n_vec++;
    send_prbs(1, 1, 0); flush();
    if (lock0 !== 1'b0) begin $display("FAIL loss_at_end: got %0d expected 0", lock0); n_err++; end
    n_vec++;
    if (bit0 !== 32'd2048) begin $display("FAIL loss_bit: got %0d expected 2048", bit0); n_err++; end
    n_vec++;
    if (lock1 !== 1'b1) begin $display("FAIL loss_lock1: got %0d expected 1", lock1); n_err++; end
    n_vec++;
    send_prbs(72, 1, 0); flush();
    if (lock0 !== 1'b0) begin $display("FAIL relock_72: got %0d expected 0", lock0); n_err++; end
    n_vec++;
    if (bit0 !== 32'd2048) begin $display("FAIL hold_bit: got %0d expected 2048", bit0); n_err++; end
    n_vec++;
    send_prbs(1, 1, 0); flush();
    if (lock0 !== 1'b1) begin $display("FAIL relock_73: got %0d expected 1", lock0); n_err++; end
    n_vec++;
    if (err0 !== 32'd18) begin $display("FAIL relock_err: got %0d expected 18", err0); n_err++; end
    n_vec++;
  endtask

  task automatic test_saturation_clear();
    send_prbs(300, 1, 1); flush();
    if (err1 !== 8'd255) begin $display("FAIL err_sat8: got %0d expected 255", err1); n_err++; end
    n_vec++;
    if (lock1 !== 1'b1) begin $display("FAIL sat_lock1: got %0d expected 1", lock1); n_err++; end
    n_vec++;
    @(posedge clk); #1 i_clear = 1'b1;
    @(posedge clk); #1 i_clear = 1'b0;
    if (bit1 !== 8'd0) begin $display("FAIL clr_bit1: got %0d expected 0", bit1); n_err++; end
    n_vec++;
    if (err1 !== 8'd0) begin $display("FAIL clr_err1: got %0d expected 0", err1); n_err++; end
    n_vec++;
    if (lock1 !== 1'b1) begin $display("FAIL clr_lock1: got %0d expected 1", lock1); n_err++; end
    n_vec++;
    if (bit0 !== 32'd0) begin $display("FAIL clr_bit0: got %0d expected 0", bit0); n_err++; end
    n_vec++;
    if (err0 !== 32'd0) begin $display("FAIL clr_err0: got %0d expected 0", err0); n_err++; end
    n_vec++;
  endtask

  task automatic test_no_lock();
    do_reset();
    seen0 = 1'b0;
    seen1 = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      send_sym(1'b0);
      if (lock0) seen0 = 1'b1;
      if (lock1) seen1 = 1'b1;
    end
    flush();
    if (seen0 !== 1'b0) begin $display("FAIL const_lock0: got %0d expected 0", seen0); n_err++; end
    n_vec++;
    if (seen1 !== 1'b0) begin $display("FAIL const_zero_ref: got %0d expected 0", seen1); n_err++; end
    n_vec++;
    if (bit0 !== 32'd0) begin $display("FAIL const_bit0: got %0d expected 0", bit0); n_err++; end
    n_vec++;
    seen0 = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      send_sym(i[0]);
      if (lock0) seen0 = 1'b1;
    end
    flush();
    if (seen0 !== 1'b0) begin $display("FAIL alt_lock0: got %0d expected 0", seen0); n_err++; end
    n_vec++;
    if (err0 !== 32'd0) begin $display("FAIL alt_err0: got %0d expected 0", err0); n_err++; end
    n_vec++;
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    i_phase = 2'd2;
    send_prbs(200, 1, 0); flush();
    if (lock0 !== 1'b1) begin $display("FAIL ph2_lock: got %0d expected 1", lock0); n_err++; end
    n_vec++;
    if (bit0 !== 32'd127) begin $display("FAIL ph2_bit: got %0d expected 127", bit0); n_err++; end
    n_vec++;
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    if (lock0 !== 1'b0) begin $display("FAIL async_lock: got %0d expected 0", lock0); n_err++; end
    n_vec++;
    if (bit0 !== 32'd0) begin $display("FAIL async_bit: got %0d expected 0", bit0); n_err++; end
    n_vec++;
    if (lock1 !== 1'b0) begin $display("FAIL async_lock1: got %0d expected 0", lock1); n_err++; end
    n_vec++;
    @(posedge clk); #3 rst_n = 1'b1;
    send_prbs(72, 1, 0); flush();
    if (lock0 !== 1'b0) begin $display("FAIL rl_72: got %0d expected 0", lock0); n_err++; end
    n_vec++;
    send_prbs(1, 1, 0); flush();
    if (lock0 !== 1'b1) begin $display("FAIL rl_73: got %0d expected 1", lock0); n_err++; end
    n_vec++;
    if (lock1 !== 1'b1) begin $display("FAIL rl1_73: got %0d expected 1", lock1); n_err++; end
    n_vec++;
    if (bit0 !== 32'd0) begin $display("FAIL rl_bit: got %0d expected 0", bit0); n_err++; end
    n_vec++;
  endtask

  initial begin
    rst_n         = 1'b0;
    i_phase       = 2'd0;
    i_clear       = 1'b0;
    s_if.i_sample = 8'h00;
    s_if.i_valid  = 1'b0;
    test_reset();
    test_clean_lock();
    test_single_errors();
    test_loss_of_lock();
    test_saturation_clear();
    test_no_lock();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
